// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and load-use hazard unit for the pipelined core. It replaces the
// old hard-wired MEM/WB bypass with a parametrised shift-register scoreboard.
// The scoreboard tracks the register writes still in flight after EX.
//
// Each cycle it does three things:
//   - picks a forwarding source for every EX operand, youngest producer first;
//   - raises a load-use stall when the youngest producer is a load whose data
//     is not ready yet;
//   - inserts a bubble into scoreboard stage 1 when EX is stalled or flushed.
//
// Parameters
//   REG_AW   register index width (index 0 is the hardwired zero register)
//   NUM_SRC  number of EX source operands resolved per cycle
//   DEPTH    scoreboard stages after EX (1=MEM, 2=WB, 3=post-WB), range 1..7
//   LOAD_RDY first stage (1-based) at which load data can be forwarded,
//            range 1..DEPTH
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-low reset; clears every scoreboard entry
//   hold_i         global freeze; the scoreboard (and the counters) keep state
//   flush_i        squashes the instruction leaving EX this cycle
//   ex_regwrite_i  EX instruction writes a register
//   ex_is_load_i   EX instruction is a load
//   ex_rd_i        EX destination register
//   ex_src_i       EX source indices; operand k is in [k*REG_AW +: REG_AW]
//   ex_src_used_i  operand k is actually read
//   fwd_sel_o      per-operand 3-bit select:
//                    0 = register file, s = forward from scoreboard stage s
//   stall_o        hold PC/IF/ID/EX this cycle; a bubble enters stage 1
//
// Optional feature: macro FWD_SCOREBOARD_PERF_EN
//   When defined, the module adds two saturating 32-bit counters:
//   perf_stall_cnt_o  counts non-hold cycles with stall_o=1
//   perf_fwd_cnt_o    counts forwarded operands on non-hold, non-stall cycles
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 3,
   parameter int LOAD_RDY = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      hold_i,
   input  logic                      flush_i,
   input  logic                      ex_regwrite_i,
   input  logic                      ex_is_load_i,
   input  logic [REG_AW-1:0]         ex_rd_i,
   input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
   input  logic [NUM_SRC-1:0]        ex_src_used_i,
   output logic [NUM_SRC*3-1:0]      fwd_sel_o,
   output logic                      stall_o
`ifdef FWD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]               perf_stall_cnt_o,
   output logic [31:0]               perf_fwd_cnt_o
`endif
);

   localparam logic [2:0] LOAD_RDY_S = 3'(LOAD_RDY);

   // Scoreboard state. Stage 1 is the instruction that left EX most recently.
   logic [DEPTH:1]    vld_q, vld_d;
   logic [DEPTH:1]    ld_q,  ld_d;
   logic [REG_AW-1:0] rd_q [1:DEPTH];
   logic [REG_AW-1:0] rd_d [1:DEPTH];

   // Per-operand load-use flags; stall_o is their OR.
   logic [NUM_SRC-1:0] luse;

   // -------------------------------------------------------------------------
   // Next-state: stage 1 captures EX, deeper stages shift by one.
   // -------------------------------------------------------------------------
   for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
      if (gi == 1) begin : g_head
         // A stalled or flushed EX instruction never becomes a producer.
         // Writes to r0 are dropped, so r0 can never match.
         assign vld_d[gi] = ex_regwrite_i & ~flush_i & ~stall_o &
                            (ex_rd_i != '0);
         assign rd_d[gi]  = ex_rd_i;
         assign ld_d[gi]  = ex_is_load_i;
      end else begin : g_shift
         assign vld_d[gi] = vld_q[gi-1];
         assign rd_d[gi]  = rd_q[gi-1];
         assign ld_d[gi]  = ld_q[gi-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         vld_q <= '0;
         ld_q  <= '0;
         for (int s = 1; s <= DEPTH; s++) begin
            rd_q[s] <= '0;
         end
      end else if (!hold_i) begin
         vld_q <= vld_d;
         ld_q  <= ld_d;
         rd_q  <= rd_d;
      end
   end

   // -------------------------------------------------------------------------
   // Operand resolution: one independent priority selector per operand.
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] src;
      logic [DEPTH:1]    hit;
      logic [2:0]        win_s;
      logic              win_ld;

      assign src = ex_src_i[gi*REG_AW +: REG_AW];

      for (genvar gj = 1; gj <= DEPTH; gj++) begin : g_hit
         assign hit[gj] = ex_src_used_i[gi] & vld_q[gj] &
                          (rd_q[gj] == src) & (src != '0);
      end

      // Scan from the oldest stage to the youngest. The last hit written
      // is therefore the youngest producer, which holds the newest value.
      always_comb begin
         win_s  = 3'd0;
         win_ld = 1'b0;
         for (int s = DEPTH; s >= 1; s--) begin
            if (hit[s]) begin
               win_s  = 3'(s);
               win_ld = ld_q[s];
            end
         end
      end

      // Only the winning producer matters. An older, ready copy of the same
      // register is stale and must not be used to avoid the stall.
      assign luse[gi] = win_ld & (win_s != 3'd0) & (win_s < LOAD_RDY_S);

      // While stalling, the operand reads the register file. The value is
      // discarded anyway because EX re-executes next cycle.
      assign fwd_sel_o[gi*3 +: 3] = luse[gi] ? 3'd0 : win_s;
   end

   assign stall_o = |luse;

`ifdef FWD_SCOREBOARD_PERF_EN
   // -------------------------------------------------------------------------
   // Performance counters, both saturating.
   // -------------------------------------------------------------------------
   logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
   logic [31:0] perf_fwd_cnt_q,   perf_fwd_cnt_d;
   logic [31:0] fwd_num;

   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   always_comb begin
      fwd_num = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         fwd_num = fwd_num + {31'd0, |fwd_sel_o[k*3 +: 3]};
      end
   end

   // A stall cycle re-executes EX next cycle. Its forwards are counted then,
   // so they are not counted twice.
   assign perf_stall_cnt_d = stall_o ? sat_add(perf_stall_cnt_q, 32'd1)
                                     : perf_stall_cnt_q;
   assign perf_fwd_cnt_d   = stall_o ? perf_fwd_cnt_q
                                     : sat_add(perf_fwd_cnt_q, fwd_num);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         perf_stall_cnt_q <= '0;
         perf_fwd_cnt_q   <= '0;
      end else if (!hold_i) begin
         perf_stall_cnt_q <= perf_stall_cnt_d;
         perf_fwd_cnt_q   <= perf_fwd_cnt_d;
      end
   end

   assign perf_stall_cnt_o = perf_stall_cnt_q;
   assign perf_fwd_cnt_o   = perf_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

   localparam int REG_AW   = 5;
   localparam int NUM_SRC  = 2;
   localparam int DEPTH    = 3;
   localparam int LOAD_RDY = 2;

   logic                      clk_i = 1'b0;
   logic                      rst_i;
   logic                      hold_i;
   logic                      flush_i;
   logic                      ex_regwrite_i;
   logic                      ex_is_load_i;
   logic [REG_AW-1:0]         ex_rd_i;
   logic [NUM_SRC*REG_AW-1:0] ex_src_i;
   logic [NUM_SRC-1:0]        ex_src_used_i;
   logic [NUM_SRC*3-1:0]      fwd_sel_o;
   logic                      stall_o;
`ifdef FWD_SCOREBOARD_PERF_EN
   logic [31:0]               perf_stall_cnt_o;
   logic [31:0]               perf_fwd_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   fwd_scoreboard #(
      .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .hold_i(hold_i),
      .flush_i(flush_i),
      .ex_regwrite_i(ex_regwrite_i),
      .ex_is_load_i(ex_is_load_i),
      .ex_rd_i(ex_rd_i),
      .ex_src_i(ex_src_i),
      .ex_src_used_i(ex_src_used_i),
      .fwd_sel_o(fwd_sel_o),
      .stall_o(stall_o)
`ifdef FWD_SCOREBOARD_PERF_EN
      ,
      .perf_stall_cnt_o(perf_stall_cnt_o),
      .perf_fwd_cnt_o(perf_fwd_cnt_o)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // One EX cycle of stimulus plus the outputs expected for it.
   typedef struct packed {
      logic       rw;
      logic       ld;
      logic [4:0] rd;
      logic [4:0] s0;
      logic [4:0] s1;
      logic [1:0] used;
      logic       hold;
      logic       flush;
      logic [2:0] e0;
      logic [2:0] e1;
      logic       est;
   } row_t;

   typedef struct {
      logic [5:0] sel;
      logic       stall;
   } exp_t;

   exp_t exp_q[$];

   function automatic row_t R(input int rw, input int ld, input int rd,
                              input int s0, input int s1, input int used,
                              input int hold, input int flush,
                              input int e0, input int e1, input int est);
      row_t r;
      r.rw = 1'(rw);  r.ld = 1'(ld);   r.rd = 5'(rd);
      r.s0 = 5'(s0);  r.s1 = 5'(s1);   r.used = 2'(used);
      r.hold = 1'(hold); r.flush = 1'(flush);
      r.e0 = 3'(e0);  r.e1 = 3'(e1);   r.est = 1'(est);
      return r;
   endfunction

   // Drive one row at the falling edge and queue its expected outputs.
   task automatic apply(input row_t r);
      exp_t e;
      @(negedge clk_i);
      ex_regwrite_i = r.rw;
      ex_is_load_i  = r.ld;
      ex_rd_i       = r.rd;
      ex_src_i      = {r.s1, r.s0};
      ex_src_used_i = r.used;
      hold_i        = r.hold;
      flush_i       = r.flush;
      e.sel         = {r.e1, r.e0};
      e.stall       = r.est;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      row_t rows[$];
      exp_t e;
      rst_i = 1'b0;
      // Junk inputs for two reset cycles: the entries must stay empty.
      for (int i = 0; i < 2; i++) begin
         apply(R(1, 1, 5, 5, 5, 3, 0, 0, 0, 0, 0));
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL reset_sel cyc%0d got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL reset_stall cyc%0d got=%b exp=%b", i, stall_o, e.stall);
         end
      end
      rows.push_back(R(0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0)); // first src r5: no match
      rows.push_back(R(1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0)); // write r6
      rows.push_back(R(0, 0, 0, 6, 0, 1, 0, 0, 1, 0, 0)); // r6 at stage 1; reset follows
      rows.push_back(R(0, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0)); // after reset: r6 is gone
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         if (i == 0 || i == 3) rst_i = 1'b1;
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL reset_seq row%0d sel got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL reset_seq row%0d stall got=%b exp=%b", i, stall_o, e.stall);
         end
         if (i == 2) rst_i = 1'b0;   // mid-operation reset at the next edge
      end
   endtask

   task automatic test_alu_chain();
      row_t rows[$];
      exp_t e;
      for (int i = 0; i < DEPTH; i++) rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(R(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0)); // add r3
      rows.push_back(R(0, 0, 0, 3, 3, 1, 0, 0, 1, 0, 0)); // src1 r3 is not used -> 0
      rows.push_back(R(0, 0, 0, 3, 0, 1, 0, 0, 2, 0, 0));
      rows.push_back(R(0, 0, 0, 3, 0, 1, 0, 0, 3, 0, 0));
      rows.push_back(R(0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0)); // past the last stage
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL alu_chain row%0d sel got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL alu_chain row%0d stall got=%b exp=%b", i, stall_o, e.stall);
         end
      end
   endtask

   task automatic test_youngest();
      row_t rows[$];
      exp_t e;
      for (int i = 0; i < DEPTH; i++) rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(R(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(R(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(R(0, 0, 0, 7, 7, 3, 0, 0, 1, 1, 0)); // both operands: youngest
      rows.push_back(R(0, 0, 0, 7, 0, 1, 0, 0, 2, 0, 0));
      rows.push_back(R(0, 0, 0, 7, 0, 1, 0, 0, 3, 0, 0));
      rows.push_back(R(1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0)); // ALU writes r8
      rows.push_back(R(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0)); // then a load to r8
      rows.push_back(R(0, 0, 0, 8, 0, 1, 0, 0, 0, 0, 1)); // the load wins -> stall
      rows.push_back(R(0, 0, 0, 8, 0, 1, 0, 0, 2, 0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL youngest row%0d sel got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL youngest row%0d stall got=%b exp=%b", i, stall_o, e.stall);
         end
      end
   endtask

   task automatic test_load_use();
      row_t rows[$];
      exp_t e;
      for (int i = 0; i < DEPTH; i++) rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(R(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));   // lw r4
      rows.push_back(R(1, 0, 10, 4, 0, 1, 0, 0, 0, 0, 1));  // consumer stalls
      rows.push_back(R(1, 0, 10, 4, 10, 3, 0, 0, 2, 0, 0)); // retry; stage 1 was a bubble
      rows.push_back(R(0, 0, 0, 10, 4, 3, 0, 0, 1, 3, 0));
      rows.push_back(R(1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0));  // lw r20
      rows.push_back(R(1, 0, 21, 20, 0, 1, 0, 1, 0, 0, 1)); // stall with flush
      rows.push_back(R(0, 0, 0, 21, 20, 3, 0, 0, 0, 2, 0)); // r21 was dropped
      rows.push_back(R(1, 1, 22, 0, 0, 0, 0, 0, 0, 0, 0));  // lw r22
      rows.push_back(R(0, 0, 0, 22, 0, 1, 1, 0, 0, 0, 1));  // stall under hold
      rows.push_back(R(0, 0, 0, 22, 0, 1, 1, 0, 0, 0, 1));
      rows.push_back(R(0, 0, 0, 22, 0, 1, 0, 0, 0, 0, 1));  // load still at stage 1
      rows.push_back(R(0, 0, 0, 22, 0, 1, 0, 0, 2, 0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL load_use row%0d sel got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL load_use row%0d stall got=%b exp=%b", i, stall_o, e.stall);
         end
      end
   endtask

   task automatic test_zero_flush_hold();
      row_t rows[$];
      exp_t e;
      for (int i = 0; i < DEPTH; i++) rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(R(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));     // write r0
      rows.push_back(R(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
      rows.push_back(R(1, 0, 9, 0, 0, 0, 0, 1, 0, 0, 0));     // flushed write r9
      rows.push_back(R(0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0));
      rows.push_back(R(1, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0));    // write r12
      rows.push_back(R(1, 0, 13, 12, 12, 3, 1, 0, 1, 1, 0));  // hold x3
      rows.push_back(R(1, 0, 13, 12, 12, 3, 1, 0, 1, 1, 0));
      rows.push_back(R(1, 0, 13, 12, 12, 3, 1, 0, 1, 1, 0));
      rows.push_back(R(0, 0, 0, 12, 13, 3, 0, 0, 1, 0, 0));   // r13 never entered
      rows.push_back(R(0, 0, 0, 12, 13, 3, 0, 0, 2, 0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL zero_flush_hold row%0d sel got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL zero_flush_hold row%0d stall got=%b exp=%b", i, stall_o, e.stall);
         end
      end
   endtask

   // Random traffic checked against a history-based reference model.
   task automatic test_random();
      logic       m_vld [1:DEPTH];
      logic       m_ld  [1:DEPTH];
      logic [4:0] m_rd  [1:DEPTH];
      row_t       r;
      exp_t       e;
      int         win;
      logic [4:0] src;
      logic [2:0] sel [0:1];
      for (int s = 1; s <= DEPTH; s++) begin
         m_vld[s] = 1'b0; m_ld[s] = 1'b0; m_rd[s] = '0;
      end
      // Start from a known state: empty the pipeline with a reset cycle.
      rst_i = 1'b0;
      apply(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      void'(exp_q.pop_front());
      rst_i = 1'b1;
      for (int c = 0; c < 300; c++) begin
         r = R(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? 1 : 0,
               ($urandom_range(0, 7) == 0) ? 1 : 0, 0, 0, 0);
         r.est = 1'b0;
         for (int k = 0; k < 2; k++) begin
            src = (k == 0) ? r.s0 : r.s1;
            win = 0;
            for (int s = 1; s <= DEPTH; s++) begin
               if (win == 0 && r.used[k] && src != 0 && m_vld[s] && m_rd[s] == src)
                  win = s;
            end
            if (win != 0 && m_ld[win] && win < LOAD_RDY) begin
               r.est  = 1'b1;
               sel[k] = 3'd0;
            end else begin
               sel[k] = 3'(win);
            end
         end
         r.e0 = sel[0];
         r.e1 = sel[1];
         apply(r);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL random cyc%0d sel got=%h exp=%h", c, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL random cyc%0d stall got=%b exp=%b", c, stall_o, e.stall);
         end
         if (!r.hold) begin
            for (int s = DEPTH; s >= 2; s--) begin
               m_vld[s] = m_vld[s-1]; m_ld[s] = m_ld[s-1]; m_rd[s] = m_rd[s-1];
            end
            m_vld[1] = r.rw && !r.flush && !r.est && (r.rd != 0);
            m_ld[1]  = r.ld;
            m_rd[1]  = r.rd;
         end
      end
   endtask

`ifdef FWD_SCOREBOARD_PERF_EN
   task automatic test_perf();
      row_t rows[$];
      exp_t e;
      rst_i = 1'b0;
      apply(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      void'(exp_q.pop_front());
      rst_i = 1'b1;
      rows.push_back(R(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));   // lw r4
      rows.push_back(R(0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 1));   // stall 1
      rows.push_back(R(1, 1, 6, 4, 0, 1, 0, 0, 2, 0, 0));   // fwd 1, lw r6
      rows.push_back(R(0, 0, 0, 6, 6, 3, 0, 0, 0, 0, 1));   // stall 2
      rows.push_back(R(1, 0, 7, 6, 6, 3, 0, 0, 2, 2, 0));   // fwd 3
      rows.push_back(R(0, 0, 0, 7, 6, 3, 0, 0, 1, 3, 0));   // fwd 5
      rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL perf row%0d sel got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
         checks++;
         if (stall_o !== e.stall) begin
            failures++;
            $display("FAIL perf row%0d stall got=%b exp=%b", i, stall_o, e.stall);
         end
      end
      checks++;
      if (perf_stall_cnt_o !== 32'd2) begin
         failures++;
         $display("FAIL perf_stall_cnt got=%0d exp=2", perf_stall_cnt_o);
      end
      checks++;
      if (perf_fwd_cnt_o !== 32'd5) begin
         failures++;
         $display("FAIL perf_fwd_cnt got=%0d exp=5", perf_fwd_cnt_o);
      end
      // Preload both counters to the maximum, then run stalls and forwards.
      force dut.perf_stall_cnt_q = 32'hFFFF_FFFF;
      force dut.perf_fwd_cnt_q   = 32'hFFFF_FFFF;
      #1;
      release dut.perf_stall_cnt_q;
      release dut.perf_fwd_cnt_q;
      rows.delete();
      rows.push_back(R(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(R(0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 1));
      rows.push_back(R(0, 0, 0, 4, 4, 3, 0, 0, 2, 2, 0));
      rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (fwd_sel_o !== e.sel) begin
            failures++;
            $display("FAIL perf_sat row%0d sel got=%h exp=%h", i, fwd_sel_o, e.sel);
         end
      end
      checks++;
      if (perf_stall_cnt_o !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL perf_stall_sat got=%h exp=ffffffff", perf_stall_cnt_o);
      end
      checks++;
      if (perf_fwd_cnt_o !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL perf_fwd_sat got=%h exp=ffffffff", perf_fwd_cnt_o);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i         = 1'b0;
      hold_i        = 1'b0;
      flush_i       = 1'b0;
      ex_regwrite_i = 1'b0;
      ex_is_load_i  = 1'b0;
      ex_rd_i       = '0;
      ex_src_i      = '0;
      ex_src_used_i = '0;
      test_reset();
      test_alu_chain();
      test_youngest();
      test_load_use();
      test_zero_flush_hold();
      test_random();
`ifdef FWD_SCOREBOARD_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined core. It is the successor to the fixed two-stage MEM/WB forwarding logic.
- Keeps an internal shift-register scoreboard of in-flight register writes DEPTH stages deep past EX.
- Resolves NUM_SRC operand forwarding selects per cycle, youngest producer first.
- Generates the load-use stall and the bubble insertion itself.

Parameters:
REG_AW, 5, register index width (32 architectural registers; index 0 is hardwired zero).
NUM_SRC, 2, number of EX source operands resolved per cycle.
DEPTH, 3, number of scoreboard stages after EX (1=MEM, 2=WB, 3=post-WB bypass); legal range 1..7.
LOAD_RDY, 2, first scoreboard stage (1-based) at which load data is forwardable; legal range 1..DEPTH.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  synchronous active-low reset, sampled on rising clk_i.
hold_i  input  1  global pipeline freeze; scoreboard and counters keep state.
flush_i  input  1  invalidates the instruction leaving EX this cycle (branch/exception squash).
ex_regwrite_i  input  1  EX instruction writes a register.
ex_is_load_i  input  1  EX instruction is a load.
ex_rd_i  input  REG_AW  EX destination register.
ex_src_i  input  NUM_SRC*REG_AW  EX source indices; operand k is in bits [k*REG_AW +: REG_AW].
ex_src_used_i  input  NUM_SRC  operand k is actually read.
fwd_sel_o  output  NUM_SRC*3  per-operand select; 0 = register file, s = forward from scoreboard stage s.
stall_o  output  1  hold PC/IF/ID/EX this cycle; a bubble enters stage 1.

Behaviour:
- Scoreboard entry s (1..DEPTH) holds {vld, rd, ld}.
- Reset (rst_i=0 at posedge): all vld=0. Since outputs are combinational from state, fwd_sel_o=0 and stall_o=0 while in reset.
- Advance at posedge when rst_i=1 and hold_i=0:
  - entry s+1 <= entry s; entry DEPTH is discarded.
  - entry 1 <= {ex_regwrite_i & ~flush_i & ~stall_o & (ex_rd_i!=0), ex_rd_i, ex_is_load_i}.
  - A stalled or flushed EX instruction inserts a bubble (vld=0) into entry 1.
- With hold_i=1: no state change. Outputs are still evaluated from current state and inputs.
- Match for operand k at stage s: ex_src_used_i[k] & vld[s] & rd[s]==src_k & src_k!=0.
- Priority: lowest s (youngest producer) wins. fwd_sel_o[k] = that s, else 0. Older matches are ignored.
- Load-use hazard: the winning match for any used operand has ld=1 and s<LOAD_RDY.
  - stall_o=1 and fwd_sel_o for that operand is forced to 0.
  - With defaults (load in MEM, consumer in EX) this gives exactly one stall cycle. On the next cycle the load is at stage 2 and forwards with sel=2.
- stall_o is a combinational output of state plus EX inputs. No same-cycle dependency on hold_i or flush_i.
- flush_i=1 together with stall_o=1: a bubble enters entry 1. The flushed instruction is dropped by the pipeline.
- Mid-operation reset clears every entry in one cycle. Stale rd values are never forwarded after reset.
- Latency: entry written at cycle t is visible as stage 1 at t+1 and as stage s at t+s, assuming no hold.
- Selection logic is purely combinational over entries. No combinational path from fwd_sel_o back into stall_o beyond the match terms.

Optional Feature:
Macro FWD_SCOREBOARD_PERF_EN.
- Defined: adds output ports perf_stall_cnt_o [31:0] and perf_fwd_cnt_o [31:0].
  - perf_stall_cnt_o increments on every non-hold cycle with stall_o=1.
  - perf_fwd_cnt_o increments by the number of operands with nonzero fwd_sel_o on every non-hold, non-stall cycle.
  - Both are saturating at 32'hFFFF_FFFF and reset to 0 by rst_i.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset: rst_i=0 for 2 cycles with garbage inputs -> fwd_sel_o=0, stall_o=0. First post-reset EX source r5 matches nothing -> sel 0.
- ALU chain, defaults: add r3 at EX in cycle t; consumer reading r3 as src0 at t+1 -> sel0=1; at t+2 -> sel0=2; at t+3 -> sel0=3; at t+4 -> sel0=0.
- Youngest wins: writes to r7 issued at t and t+1, consumer of r7 at t+2 -> sel=1 (not 2). Both operands r7 -> both sel=1.
- Load-use: lw r4 at t, consumer of r4 at t+1 -> stall_o=1, sel=0. Consumer held at t+2 -> stall_o=0, sel=2. Entry 1 at t+2 is a bubble.
- Zero register, flush and hold: write to r0 then consumer of r0 -> sel=0. Flushed write to r9 then consumer of r9 -> sel=0. hold_i=1 for 3 cycles -> sel values are unchanged across the hold.
- PERF_EN: a sequence with 2 load-use stalls and 5 forwarded operands -> perf_stall_cnt_o=2, perf_fwd_cnt_o=5. Preload counter to max -> it stays at FFFF_FFFF.
